// File: rtl/freq_key_sel.sv
// Two-button frequency selector: synchronise, debounce and edge-detect each key,
// then step the 2-bit clk_key code up or down with wrap-around.

module freq_key_deb #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } deb_state_e;

    deb_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!key_n) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (key_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (key_n) begin
                    state_d = REL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_WAIT: begin
                // A bounce during release returns to HELD so no second pulse
                if (!key_n) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pulse = pulse_q;

endmodule

module freq_key_sel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    output logic [1:0] clk_key,
    output logic       sel_changed,
    output logic       key_up_pulse,
    output logic       key_down_pulse
);

    logic [1:0] up_sync_q, up_sync_d;
    logic [1:0] dn_sync_q, dn_sync_d;
    logic [1:0] clk_key_q, clk_key_d;
    logic       sel_changed_q, sel_changed_d;
    logic       up_pulse, dn_pulse;

    // Synchronisers idle at 1 so reset looks like a released key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_sync_q     <= 2'b11;
            dn_sync_q     <= 2'b11;
            clk_key_q     <= 2'd0;
            sel_changed_q <= 1'b0;
        end else begin
            up_sync_q     <= up_sync_d;
            dn_sync_q     <= dn_sync_d;
            clk_key_q     <= clk_key_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    always_comb begin
        up_sync_d = {up_sync_q[0], key_up_n};
        dn_sync_d = {dn_sync_q[0], key_down_n};
    end

    freq_key_deb #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(up_sync_q[1]),
        .pulse(up_pulse)
    );

    freq_key_deb #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_dn (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(dn_sync_q[1]),
        .pulse(dn_pulse)
    );

    // Simultaneous up and down cancel out
    always_comb begin
        clk_key_d     = clk_key_q;
        sel_changed_d = 1'b0;
        unique case ({up_pulse, dn_pulse})
            2'b10: begin
                clk_key_d     = clk_key_q + 2'd1;
                sel_changed_d = 1'b1;
            end
            2'b01: begin
                clk_key_d     = clk_key_q - 2'd1;
                sel_changed_d = 1'b1;
            end
            default: begin
                clk_key_d     = clk_key_q;
                sel_changed_d = 1'b0;
            end
        endcase
    end

    assign clk_key        = clk_key_q;
    assign sel_changed    = sel_changed_q;
    assign key_up_pulse   = up_pulse;
    assign key_down_pulse = dn_pulse;

endmodule

// File: tb/tb_freq_key_sel.sv
// Directed bench for freq_key_sel with DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_freq_key_sel;

    logic       clk;
    logic       rst_n;
    logic       key_up_n;
    logic       key_down_n;
    logic [1:0] clk_key;
    logic       sel_changed;
    logic       key_up_pulse;
    logic       key_down_pulse;

    int n_chk;
    int n_fail;

    freq_key_sel #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_up_n      (key_up_n),
        .key_down_n    (key_down_n),
        .clk_key       (clk_key),
        .sel_changed   (sel_changed),
        .key_up_pulse  (key_up_pulse),
        .key_down_pulse(key_down_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic up_press(input logic [1:0] exp_key);
        key_up_n = 1'b0;
        repeat (10) tick();
        chk("up_seq", {6'd0, clk_key}, {6'd0, exp_key});
        key_up_n = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        key_up_n   = 1'b1;
        key_down_n = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_key", {6'd0, clk_key}, 8'd0);
        chk("rst_chg", {7'd0, sel_changed}, 8'd0);
        chk("rst_upp", {7'd0, key_up_pulse}, 8'd0);
        chk("rst_dnp", {7'd0, key_down_pulse}, 8'd0);
        rst_n = 1'b1;

        // Idle 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", {3'd0, clk_key, sel_changed, key_up_pulse,
                         key_down_pulse}, 8'd0);
        end

        // Single up press held 20 cycles: pulse after E6, key change at E7
        key_up_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("hold_upp", {7'd0, key_up_pulse}, (i == 7) ? 8'd1 : 8'd0);
            chk("hold_key", {6'd0, clk_key}, (i >= 8) ? 8'd1 : 8'd0);
            chk("hold_chg", {7'd0, sel_changed}, (i == 8) ? 8'd1 : 8'd0);
        end
        key_up_n = 1'b1;
        repeat (10) tick();

        // Four up presses wrap 1,2,3,0 then one down press gives 3
        do_reset();
        chk("rst2_key", {6'd0, clk_key}, 8'd0);
        up_press(2'd1);
        up_press(2'd2);
        up_press(2'd3);
        up_press(2'd0);
        key_down_n = 1'b0;
        repeat (10) tick();
        chk("down_wrap", {6'd0, clk_key}, 8'd3);
        key_down_n = 1'b1;
        repeat (10) tick();

        // Bouncing down key: only the final stable low counts
        key_down_n = 1'b0;
        repeat (3) begin
            tick();
            chk("bnc_dnp", {7'd0, key_down_pulse}, 8'd0);
        end
        key_down_n = 1'b1;
        tick();
        chk("bnc_dnp", {7'd0, key_down_pulse}, 8'd0);
        key_down_n = 1'b0;
        repeat (2) begin
            tick();
            chk("bnc_dnp", {7'd0, key_down_pulse}, 8'd0);
        end
        key_down_n = 1'b1;
        repeat (2) begin
            tick();
            chk("bnc_dnp", {7'd0, key_down_pulse}, 8'd0);
        end
        key_down_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("bnc_fin_dnp", {7'd0, key_down_pulse},
                (i == 7) ? 8'd1 : 8'd0);
            chk("bnc_fin_key", {6'd0, clk_key}, (i >= 8) ? 8'd2 : 8'd3);
        end
        key_down_n = 1'b1;
        repeat (10) tick();

        // Both keys together: pulses coincide, selection unchanged
        key_up_n   = 1'b0;
        key_down_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("both_upp", {7'd0, key_up_pulse}, (i == 7) ? 8'd1 : 8'd0);
            chk("both_dnp", {7'd0, key_down_pulse}, (i == 7) ? 8'd1 : 8'd0);
            chk("both_key", {6'd0, clk_key}, 8'd2);
            chk("both_chg", {7'd0, sel_changed}, 8'd0);
        end
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (10) tick();

        // Async reset mid PRESS_WAIT with clk_key=2
        chk("pre_rst_key", {6'd0, clk_key}, 8'd2);
        key_up_n = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("async_key", {6'd0, clk_key}, 8'd0);
        chk("async_upp", {7'd0, key_up_pulse}, 8'd0);
        tick();
        tick();
        chk("in_rst_key", {6'd0, clk_key}, 8'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("rel_upp", {7'd0, key_up_pulse}, (i == 7) ? 8'd1 : 8'd0);
            chk("rel_key", {6'd0, clk_key}, (i >= 8) ? 8'd1 : 8'd0);
            chk("rel_chg", {7'd0, sel_changed}, (i == 8) ? 8'd1 : 8'd0);
        end
        key_up_n = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
